// File: rtl/lane_bus_pkg.sv
// lane_bus_pkg: shared types for the lane bus arbiter slice.
// Holds default lane geometry, the beat payload type and FSM states.
package lane_bus_pkg;

  localparam int NLANE_D = 3;
  localparam int DW_D    = 8;

  typedef logic [0:NLANE_D-1][DW_D-1:0] lane_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports: req_i request vector, last_i previous winner,
//        found_o any request, win_o first request after last_i.
module rr_pick
  import lane_bus_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] win_o
);

  int idx;

  // Scan last_i+1 .. last_i+N modulo N; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    win_o   = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      if (!found_o && req_i[IW'(idx)]) begin
        found_o = 1'b1;
        win_o   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/lane_bus_arbiter.sv
// lane_bus_arbiter: round-robin burst arbiter for a multi-lane byte bus.
// Ports: req_valid/req_last/req_data/req_ready per producer;
//        out_valid/out_last/out_data/out_src/out_ready to the consumer;
//        busy (grant locked), owner (last grant), err_burst (forced release).
module lane_bus_arbiter
  import lane_bus_pkg::*;
#(
  parameter  int NREQ      = 2,
  parameter  int NLANE     = NLANE_D,
  parameter  int DW        = DW_D,
  parameter  int MAX_BURST = 16,
  localparam int IDW       = idx_w(NREQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ-1:0]                     req_last,
  input  logic [NREQ-1:0][0:NLANE-1][DW-1:0]  req_data,
  output logic [NREQ-1:0]                     req_ready,
  output logic                                out_valid,
  output logic                                out_last,
  output logic [0:NLANE-1][DW-1:0]            out_data,
  output logic [IDW-1:0]                      out_src,
  input  logic                                out_ready,
  output logic                                busy,
  output logic [IDW-1:0]                      owner,
  output logic                                err_burst
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic           accept;
  logic           found;
  logic           fire;
  logic           last_w;
  logic           forced;
  logic [IDW-1:0] win;
  logic [IDW-1:0] sel;
  logic [CW-1:0]  beats;

  rr_pick #(
    .N(NREQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (owner),
    .found_o(found),
    .win_o  (win)
  );

  // accept only looks at the output register, so out_ready reaches
  // req_ready through this single term.
  always_comb begin
    accept  = !out_valid || out_ready;
    sel     = (state_q == LOCK) ? owner : win;
    fire    = accept &&
              ((state_q == LOCK) ? req_valid[owner] : found);
    req_ready = '0;
    if (fire) req_ready[sel] = 1'b1;
    last_w  = req_last[sel];
    beats   = (state_q == LOCK) ? cnt_q + 1'b1 : CW'(1);
    // A non-last beat that fills the burst budget ends the grant.
    forced  = !last_w && (beats == CW'(MAX_BURST));
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fire) begin
      if (!last_w && !forced) begin
        state_d = LOCK;
        cnt_d   = beats;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner     <= IDW'(NREQ - 1);
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_burst <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_burst <= fire && forced;
      if (fire) begin
        owner     <= sel;
        out_valid <= 1'b1;
        out_last  <= last_w || forced;
        out_data  <= req_data[sel];
        out_src   <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q == LOCK);

endmodule

// File: tb/tb_lane_bus_arbiter.sv
// tb_lane_bus_arbiter: random and directed checks of lane_bus_arbiter
// against a behavioural reference model and a beat scoreboard.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_lane_bus_arbiter;
  import lane_bus_pkg::*;

  localparam int NREQ = 3;
  localparam int MAXB = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  lane_beat_t [NREQ-1:0] req_data;
  logic out_valid, out_last, out_ready;
  logic busy, err_burst;
  lane_beat_t out_data;
  logic [IDW-1:0] out_src, owner;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  lane_bus_arbiter #(
    .NREQ(NREQ), .NLANE(3), .DW(8), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last),
    .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy),
    .owner(owner), .err_burst(err_burst)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
  endtask

  bit m_lock, m_ov, m_ol, m_err;
  int m_own, m_cnt, m_os;
  lane_beat_t m_od;
  lane_beat_t sb_d[$];
  int sb_s[$];
  int m_w, m_j, m_beats;
  bit m_forced;
  logic [NREQ-1:0] m_rdy;

  always @(negedge clk) begin : model
    if (!rst_n) begin
      m_lock = 0; m_ov = 0; m_ol = 0; m_err = 0;
      m_own = NREQ - 1; m_cnt = 0; m_os = 0; m_od = '0;
      sb_d.delete(); sb_s.delete();
    end
    chk_cnt++;
    if (out_valid !== m_ov)
      $display("FAIL out_valid: got %b exp %b at %0t",
               out_valid, m_ov, $time);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== m_lock)
      $display("FAIL busy: got %b exp %b at %0t",
               busy, m_lock, $time);
    else pass_cnt++;
    chk_cnt++;
    if (owner !== IDW'(m_own))
      $display("FAIL owner: got %0d exp %0d at %0t",
               owner, m_own, $time);
    else pass_cnt++;
    chk_cnt++;
    if (err_burst !== m_err)
      $display("FAIL err_burst: got %b exp %b at %0t",
               err_burst, m_err, $time);
    else pass_cnt++;
    if (m_ov) begin
      `CHK("out_data", out_data, m_od);
      `CHK("out_src", out_src, m_os);
      `CHK("out_last", out_last, m_ol);
    end
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_d.size() == 0) begin
          `CHK("sb_extra_beat", 1, 0);
        end else begin
          `CHK("sb_data", out_data, sb_d.pop_front());
          `CHK("sb_src", out_src, sb_s.pop_front());
        end
      end
      m_w = -1;
      if (!m_ov || out_ready) begin
        if (m_lock) begin
          if (req_valid[m_own]) m_w = m_own;
        end else begin
          for (int k = 1; k <= NREQ; k++) begin
            m_j = (m_own + k) % NREQ;
            if (m_w < 0 && req_valid[m_j]) m_w = m_j;
          end
        end
      end
      m_rdy = '0;
      if (m_w >= 0) m_rdy[m_w] = 1'b1;
      chk_cnt++;
      if (req_ready !== m_rdy)
        $display("FAIL req_ready: got %b exp %b at %0t",
                 req_ready, m_rdy, $time);
      else pass_cnt++;
      m_err = 0;
      if (m_w >= 0) begin
        m_beats  = m_lock ? m_cnt + 1 : 1;
        m_forced = !req_last[m_w] && (m_beats == MAXB);
        m_od  = req_data[m_w];
        m_os  = m_w;
        m_ol  = req_last[m_w] || m_forced;
        m_ov  = 1;
        m_err = m_forced;
        m_own = m_w;
        m_lock = !req_last[m_w] && !m_forced;
        m_cnt = m_beats;
        sb_d.push_back(m_od);
        sb_s.push_back(m_os);
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    `CHK("rst_out_valid", out_valid, 0);
    `CHK("rst_out_last", out_last, 0);
    `CHK("rst_out_data", out_data, 0);
    `CHK("rst_out_src", out_src, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_owner", owner, NREQ - 1);
    `CHK("rst_err", err_burst, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] fired;
  logic f0;
  int b;

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    #2;
    do_reset();

    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < NREQ; i++)
      req_data[i] = 24'(i + 1) * 24'h010101;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) `CHK("fair_ready", req_ready, 1 << (k % 3));
      if (k > 0) begin
        `CHK("fair_valid", out_valid, 1);
        `CHK("fair_src", out_src, (k - 1) % 3);
      end
    end
    step();
    req_valid = '0;
    step();
    step();
    do_reset();

    req_valid = 3'b011;
    req_last  = 3'b010;
    b = 0;
    req_data[0] = 24'h100000;
    req_data[1] = 24'h222222;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      f0 = req_ready[0];
      if (cyc < 4) `CHK("lock_ready", req_ready, 3'b001);
      if (cyc >= 1 && cyc <= 4) begin
        `CHK("lock_src", out_src, 0);
        `CHK("lock_busy", busy, cyc < 4);
        `CHK("lock_data", out_data, 24'h100000 + cyc - 1);
      end
      if (cyc == 4) begin
        `CHK("lock_rel_ready", req_ready, 3'b010);
        `CHK("lock_last", out_last, 1);
      end
      if (cyc == 5) `CHK("lock_next_src", out_src, 1);
      step();
      if (f0) begin
        b++;
        if (b == 4) req_valid[0] = 1'b0;
        else begin
          req_data[0] = 24'h100000 + 24'(b);
          req_last[0] = (b == 3);
        end
      end
    end
    req_valid = '0;
    step();
    step();
    do_reset();

    out_ready = 1'b0;
    req_valid = 3'b001;
    req_last  = 3'b001;
    req_data[0] = 24'hAABBCC;
    @(negedge clk);
    `CHK("bp_first_ready", req_ready, 3'b001);
    step();
    req_data[0] = 24'h112233;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      `CHK("bp_hold_data", out_data, 24'hAABBCC);
      `CHK("bp_no_ready", req_ready, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    `CHK("bp_resume_ready", req_ready, 3'b001);
    `CHK("bp_resume_data", out_data, 24'hAABBCC);
    step();
    req_valid = '0;
    @(negedge clk);
    `CHK("bp_next_data", out_data, 24'h112233);
    `CHK("bp_next_valid", out_valid, 1);
    step();
    @(negedge clk);
    `CHK("bp_drained", out_valid, 0);
    step();
    do_reset();

    req_valid = 3'b110;
    req_last  = 3'b100;
    b = 0;
    req_data[1] = 24'h010100;
    req_data[2] = 24'h333333;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      f0 = req_ready[1];
      if (cyc < 4) `CHK("frc_ready", req_ready, 3'b010);
      if (cyc == 3) begin
        `CHK("frc_nolast", out_last, 0);
        `CHK("frc_noerr", err_burst, 0);
      end
      if (cyc == 4) begin
        `CHK("frc_next_ready", req_ready, 3'b100);
        `CHK("frc_last", out_last, 1);
        `CHK("frc_err", err_burst, 1);
        `CHK("frc_src", out_src, 1);
      end
      if (cyc == 5) begin
        `CHK("frc_err_pulse", err_burst, 0);
        `CHK("frc_src2", out_src, 2);
      end
      step();
      if (f0) begin
        b++;
        req_data[1] = 24'h010100 + 24'(b);
      end
    end
    req_valid = '0;
    step();
    step();
    do_reset();

    req_valid = 3'b001;
    req_last  = 3'b000;
    req_data[0] = 24'h404040;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    `CHK("rmb_busy_before", busy, 1);
    req_valid = 3'b011;
    req_last  = 3'b011;
    do_reset();
    @(negedge clk);
    `CHK("rmb_ready", req_ready, 3'b001);
    `CHK("rmb_idle", busy, 0);
    step();
    req_valid = '0;
    step();

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      fired = req_valid & req_ready;
      step();
      if (c == 700) do_reset();
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || fired[i]) begin
          req_valid[i] = ($urandom_range(2) != 0);
          req_last[i]  = ($urandom_range(3) == 0);
          req_data[i]  = 24'($urandom);
        end
      end
    end
    req_valid = '0;
    out_ready = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lane_bus_arbiter.md
Name: lane_bus_arbiter

Overview:
- Shares the multi-lane byte-array bus between NREQ producer sub-blocks. Each producer presents a packed [0:NLANE-1][DW-1:0] beat. A single downstream consumer receives the beats.
- Arbitration is round-robin. A grant is held for a burst, which ends on the requester's last beat, or is forced to end after MAX_BURST beats.
- One registered output stage; no combinational path from out_ready to req_ready other than through the output-stage "can accept" term.
- Sits at top level between the sub1-style producers and the sub2-style consumer. Replaces hand-wired point-to-point hookup of the lane arrays.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NLANE, 3, lanes per beat.
- DW, 8, bits per lane.
- MAX_BURST, 16, maximum beats per grant before forced release (>=1).
- IDW, $clog2(NREQ) (min 1), requester index width (derived, localparam).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of burst.
- req_data  input  [NREQ][NLANE][DW]  per-requester beat payload.
- req_ready  output  NREQ  per-requester beat accepted (one-hot or zero).
- out_valid  output  1  output beat valid.
- out_last  output  1  output beat is last of burst (the forced-release beat also has this set).
- out_data  output  [NLANE][DW]  output payload.
- out_src  output  IDW  index of requester that sourced out_data.
- out_ready  input  1  consumer accepts beat.
- busy  output  1  grant currently locked to an owner (state LOCK).
- owner  output  IDW  current or last granted requester.
- err_burst  output  1  one-cycle pulse on forced release at MAX_BURST.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_last=0, out_data=0, out_src=0, busy=0, owner=NREQ-1 (so requester 0 has first priority), err_burst=0, beat counter=0.
- Accept condition: accept = !out_valid || out_ready.
- Handshake: a beat transfers on req_valid[i] && req_ready[i]. req_ready is combinational from state, req_valid and accept, and is never asserted when accept=0. Requesters hold data and last stable until ready.
- Latency: an accepted beat appears on out_* the next cycle. Throughput is one beat per cycle under continuous out_ready.
- State machine:
  - IDLE: when accept=1 and any req_valid, pick the winner w as the first valid index searching from owner+1 modulo NREQ. Assert req_ready[w], capture the beat, set owner=w and count=1.
    - If req_last[w]=0 and MAX_BURST>1, go to LOCK.
    - Otherwise stay in IDLE.
  - LOCK: only req_ready[owner] may assert. Other requesters are ignored even if valid. On each accepted owner beat, count increments.
    - If req_last[owner]=1, go to IDLE.
    - Else if count+1==MAX_BURST, go to IDLE, force out_last=1 on that beat, and pulse err_burst the cycle the beat lands in the output register.
  - An idle owner in LOCK (req_valid low) keeps the grant indefinitely; there is no timeout on idle.
- Output register:
  - Loads when a beat is accepted.
  - When out_ready=1 and no new beat is accepted, out_valid falls to 0.
  - out_data, out_src and out_last hold while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A consumer pop and a new capture in the same cycle is a back-to-back transfer with no bubble.
  - All requesters valid: service order under single-beat bursts is 0,1,...,NREQ-1,0,...
- Single requester: NREQ rotation is skipped naturally; the same requester wins every cycle.
- Reset mid-burst: LOCK is abandoned, the output beat is dropped, and state returns to IDLE with reset values.
- Counter width: $clog2(MAX_BURST+1). It never wraps, because forced release occurs at MAX_BURST.

Decomposition:
- Shared package lane_bus_pkg:
  - default NLANE and DW constants;
  - typedef lane_beat_t, a logic [0:NLANE-1][DW-1:0] payload type;
  - typedef arb_state_e {IDLE, LOCK}.
- Sub-module rr_pick: a combinational round-robin priority picker. Inputs are the request vector and the last-owner index. Outputs are found and the winner index.
- The top level contains the FSM, the beat counter and the output register.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-traffic. Every output must take its reset value asynchronously with no clk edge; after release, owner=NREQ-1 and busy=0.
- Fairness: NREQ=3, all req_valid=1, all req_last=1, out_ready=1. out_src sequence must be 0,1,2,0,1,2 on consecutive cycles, with out_valid continuously 1 from cycle 1.
- Burst lock: req0 sends 4 beats with last on beat 4 while req1 is valid throughout. Required: out_src=0 for 4 beats, busy=1 during them, then out_src=1; req_ready[1]=0 during the lock.
- Backpressure: out_ready=0 for 5 cycles with out_data=0xAA_BB_CC held. out_data must stay stable, req_ready must be all zero, and no beat may be lost or duplicated after out_ready returns to 1.
- Forced release: MAX_BURST=4, req1 never asserts last. Beat 4 must appear with out_last=1 and err_burst pulsing for one cycle. The next grant goes to req2 if it is valid, otherwise to req1 again.
- Reset mid-burst: assert rst_n=0 while busy=1 after 2 beats. After release, state is IDLE, and the first grant follows reset priority (req0 wins if valid).
